// File: rtl/clk_enable_controller_pkg.sv
// Shared state encodings and helpers for the clk_enable_controller slice.
package clk_enable_controller_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] ST_PAUSE = 2'd2;
  localparam logic [STATE_W-1:0] ST_STEP  = 2'd3;

  function automatic logic state_is_counting(input logic [STATE_W-1:0] st);
    return (st == ST_RUN) || (st == ST_STEP);
  endfunction

endpackage

// File: rtl/clk_enable_controller_divider.sv
// Terminal-count divider: counter, active/pending divisor, tick and clk_out generation.
module clk_enable_controller_divider
  import clk_enable_controller_pkg::*;
#(
  parameter int unsigned         CNT_W       = 27,
  parameter logic [CNT_W-1:0]    DEFAULT_DIV = CNT_W'(199_999)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             idle_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_value_i,
  output logic             wrap_o,
  output logic             tick_o,
  output logic             clk_out_o
);

  logic [CNT_W-1:0] count_d, count_q;
  logic [CNT_W-1:0] div_active_d, div_active_q;
  logic [CNT_W-1:0] div_pending_d, div_pending_q;
  logic             tick_d, tick_q;
  logic             clk_out_d, clk_out_q;
  logic             wrap_eff;

  assign wrap_o   = en_i && (count_q == div_active_q);
  assign wrap_eff = wrap_o && !clr_i;

  always_comb begin
    count_d       = count_q;
    tick_d        = 1'b0;
    clk_out_d     = clk_out_q;
    div_pending_d = load_i ? load_value_i : div_pending_q;
    div_active_d  = div_active_q;

    if (clr_i) begin
      count_d = '0;
    end else if (wrap_eff) begin
      count_d   = '0;
      tick_d    = 1'b1;
      clk_out_d = ~clk_out_q;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end

    // Divisor only switches on a period boundary (or while stopped), so no runt periods.
    if (wrap_eff || idle_i) begin
      div_active_d = div_pending_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q       <= '0;
      div_active_q  <= DEFAULT_DIV;
      div_pending_q <= DEFAULT_DIV;
      tick_q        <= 1'b0;
      clk_out_q     <= 1'b0;
    end else begin
      count_q       <= count_d;
      div_active_q  <= div_active_d;
      div_pending_q <= div_pending_d;
      tick_q        <= tick_d;
      clk_out_q     <= clk_out_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = clk_out_q;

endmodule

// File: rtl/clk_enable_controller.sv
// Run/pause/single-step controller around a programmable divider.
// Optional tick counter enabled by defining CLK_CTRL_TICK_COUNT_EN.
module clk_enable_controller
  import clk_enable_controller_pkg::*;
#(
  parameter int unsigned         CNT_W       = 27,
  parameter logic [CNT_W-1:0]    DEFAULT_DIV = CNT_W'(199_999)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_start,
  input  logic               cmd_stop,
  input  logic               cmd_pause,
  input  logic               cmd_step,
  input  logic               div_load,
  input  logic [CNT_W-1:0]   div_value,
  output logic               tick,
  output logic               clk_out,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic [15:0]        tick_count
);

  logic [STATE_W-1:0] state_d, state_q;
  logic               busy_d, busy_q;
  logic               en, clr, idle, wrap;

  assign en   = state_is_counting(state_q);
  assign idle = (state_q == ST_IDLE);
  assign clr  = (state_d == ST_IDLE);

  // Commands with no meaning in the current state are ignored rather than blocking others.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_step)       state_d = ST_STEP;
        else if (cmd_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cmd_stop)       state_d = ST_IDLE;
        else if (cmd_pause) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (cmd_stop)       state_d = ST_IDLE;
        else if (cmd_step)  state_d = ST_STEP;
        else if (cmd_start) state_d = ST_RUN;
      end
      ST_STEP: begin
        if (cmd_stop)       state_d = ST_IDLE;
        else if (wrap)      state_d = ST_PAUSE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = state_is_counting(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  clk_enable_controller_divider #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_divider (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .clr_i        (clr),
    .idle_i       (idle),
    .load_i       (div_load),
    .load_value_i (div_value),
    .wrap_o       (wrap),
    .tick_o       (tick),
    .clk_out_o    (clk_out)
  );

  assign state = state_q;
  assign busy  = busy_q;

`ifdef CLK_CTRL_TICK_COUNT_EN
  logic [15:0] tick_count_d, tick_count_q;

  always_comb begin
    tick_count_d = tick_count_q;
    if (clr)       tick_count_d = '0;
    else if (wrap) tick_count_d = tick_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) tick_count_q <= '0;
    else     tick_count_q <= tick_count_d;
  end

  assign tick_count = tick_count_q;
`else
  assign tick_count = 16'h0;
`endif

endmodule

// File: tb/tb_clk_enable_controller.sv
// Directed bench for clk_enable_controller with DEFAULT_DIV = 4.
module tb_clk_enable_controller;

  logic        clk;
  logic        rst;
  logic        cmd_start, cmd_stop, cmd_pause, cmd_step, div_load;
  logic [26:0] div_value;
  logic        tick, clk_out, busy;
  logic [1:0]  state;
  logic [15:0] tick_count;

  int n_checks = 0;
  int n_fail   = 0;

  clk_enable_controller #(
    .CNT_W       (27),
    .DEFAULT_DIV (27'd4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_start  (cmd_start),
    .cmd_stop   (cmd_stop),
    .cmd_pause  (cmd_pause),
    .cmd_step   (cmd_step),
    .div_load   (div_load),
    .div_value  (div_value),
    .tick       (tick),
    .clk_out    (clk_out),
    .state      (state),
    .busy       (busy),
    .tick_count (tick_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start, stop, pause, step, load;
    logic [26:0] dv;
    logic        tick, clk_out;
    logic [1:0]  state;
    logic        busy;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic s, input logic sp, input logic p, input logic st,
                              input logic ld, input logic [26:0] dv, input logic t,
                              input logic co, input logic [1:0] sta, input logic b);
    vec_t v;
    v.start = s; v.stop = sp; v.pause = p; v.step = st; v.load = ld; v.dv = dv;
    v.tick = t; v.clk_out = co; v.state = sta; v.busy = b;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cmds();
    cmd_start = 0; cmd_stop = 0; cmd_pause = 0; cmd_step = 0; div_load = 0; div_value = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Clocks idle cycles until tick is seen; returns through a check of the cycle count.
  task automatic wait_tick(input string name, input int exp);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (tick !== 1'b1 && n < 100);
    chk(name, n, exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic any_tick;

    // Test 1 table: start then free-run, period 5 ticks, clk_out period 10.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'd1, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 2'd1, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'd1, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 1, 2'd1, 1);

    idle_cmds();
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    chk("reset_outputs", {tick, clk_out, state, busy}, 5'b0);
    chk("reset_tick_count", tick_count, 0);

    for (int i = 0; i < 16; i++) begin
      cmd_start = tbl[i].start; cmd_stop = tbl[i].stop; cmd_pause = tbl[i].pause;
      cmd_step  = tbl[i].step;  div_load = tbl[i].load; div_value = tbl[i].dv;
      cyc();
      chk($sformatf("vec%0d", i), {tick, clk_out, state, busy},
          {tbl[i].tick, tbl[i].clk_out, tbl[i].state, tbl[i].busy});
    end
    idle_cmds();

    // Test 2: pause with count frozen at 2, resume finishes the period.
    cyc();
    cmd_pause = 1; cyc(); cmd_pause = 0;
    chk("pause_state", {state, busy}, {2'd2, 1'b0});
    any_tick = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      any_tick |= tick;
    end
    chk("pause_no_tick", any_tick, 0);
    chk("pause_hold_state", state, 2);
    cmd_start = 1; cyc(); cmd_start = 0;
    chk("resume_state", {state, busy}, {2'd1, 1'b1});
    wait_tick("resume_tick", 3);
    chk("resume_clk_out", clk_out, 0);

    // Test 3: single step from PAUSE, mid-period and then from count 0.
    cmd_pause = 1; cyc(); cmd_pause = 0;
    cmd_step = 1; cyc(); cmd_step = 0;
    chk("step1_state", {state, busy}, {2'd3, 1'b1});
    wait_tick("step1_tick", 4);
    chk("step1_back_pause", {state, busy}, {2'd2, 1'b0});
    cmd_step = 1; cyc(); cmd_step = 0;
    chk("step2_state", state, 3);
    wait_tick("step2_tick", 5);
    chk("step2_back_pause", state, 2);
    any_tick = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      any_tick |= tick;
    end
    chk("step_single_tick", any_tick, 0);

    // Test 4: runtime divisor changes take effect only at the wrap.
    cmd_start = 1; cyc(); cmd_start = 0;
    wait_tick("run_again", 5);
    cyc();
    div_load = 1; div_value = 27'd1; cyc(); idle_cmds();
    wait_tick("load_cur_period", 3);
    wait_tick("div1_a", 2);
    wait_tick("div1_b", 2);
    div_load = 1; div_value = 27'd0; cyc(); idle_cmds();
    wait_tick("div0_first", 1);
    wait_tick("div0_a", 1);
    wait_tick("div0_b", 1);
    div_load = 1; div_value = 27'd3; cyc(); idle_cmds();
    chk("load_on_wrap_tick", tick, 1);
    wait_tick("div3_period", 4);
    chk("clk_out_before_stop", clk_out, 1);

    // Test 5: stop wins over pause/start; clk_out level preserved; reset mid-run.
    cmd_stop = 1; cmd_pause = 1; cmd_start = 1; cyc(); idle_cmds();
    chk("stop_prio", {tick, state, busy}, {1'b0, 2'd0, 1'b0});
    chk("stop_clk_out_kept", clk_out, 1);
    chk("stop_tick_count", tick_count, 0);
    cmd_start = 1; cyc(); cmd_start = 0;
    wait_tick("after_stop_count0", 4);
    wait_tick("after_stop_2", 4);
    cyc();
    rst = 1; cyc(); rst = 0;
    chk("rst_run_outputs", {tick, clk_out, state, busy}, 5'b0);
    chk("rst_run_tick_count", tick_count, 0);
    cmd_start = 1; cyc(); cmd_start = 0;
    wait_tick("rst_default_div", 5);

    // Test 6: tick counter wrap after 65537 ticks.
    cmd_stop = 1; cyc(); cmd_stop = 0;
    div_load = 1; div_value = 27'd0; cyc(); idle_cmds();
    cmd_start = 1; cyc(); cmd_start = 0;
    for (int i = 0; i < 65536; i++) cyc();
    cmd_pause = 1; cyc(); cmd_pause = 0;
    chk("long_run_state", state, 2);
`ifdef CLK_CTRL_TICK_COUNT_EN
    chk("tick_count_wrap", tick_count, 1);
`else
    chk("tick_count_off", tick_count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
